ccd_capture_sequencer: RTL and testbench
========================================

# ccd_capture_sequencer

Avalon-MM controlled capture sequencer for the camera path. It runs on the system clock and turns host register writes into frame-aligned start and end pulses for the CCD capture stage. Capture can run continuously or as a snapshot of N frames. The block watches the sensor's frame-valid line to count completed frames, detect stalls and raise an interrupt. It sits between the Qsys host interface and the capture/RGB datapath, alongside the reset-delay and I2C sensor-configuration logic.

## Interface
- TIMEOUT_CYCLES, 50_000_000, iclk cycles without a frame-valid edge before a run aborts with an error (1 s at 50 MHz).
- iclk  in  1  system clock, the only clock in the block.
- irst  in  1  reset; synchronous to iclk and active-high.
- iaddress  in  3  Avalon-MM word address.
- iread  in  1  Avalon-MM read strobe.
- iwrite  in  1  Avalon-MM write strobe.
- iwritedata  in  32  Avalon-MM write data.
- oreaddata  out  32  Avalon-MM read data; valid one cycle after iread.
- ifval  in  1  raw sensor FVAL; asynchronous to iclk.
- ostart  out  1  one-cycle pulse that enables capture; drives the capture stage's START input.
- oend  out  1  one-cycle pulse that stops capture; drives the capture stage's END input.
- obusy  out  1  high while in the ARM, RUN or STOP states.
- oirq  out  1  level interrupt, equal to done & irq_en.

## Operation
- **FVAL synchronizer and edge detect:** ifval passes through a 2-flop synchronizer, then one delay flop for edge detection.
  - fs denotes the synchronized level.
  - fall denotes fs 1→0, marking the end of a frame.
  - rise denotes fs 0→1.
- **Register map (word addresses):**
  - 0 CTRL (write-only; reads 0). Action bits:
    - bit0 START: continuous capture.
    - bit1 STOP.
    - bit2 SNAP: capture N frames.
    - bit3 IRQ_EN: stored level, updated on every CTRL write.
  - 1 NFRAMES (read/write, [15:0]). Reset value 1. A value of 0 is treated as 1.
  - 2 STATUS (read):
    - bit0 busy.
    - bit1 done (sticky).
    - bit2 timeout error (sticky).
    - bit3 snap mode.
    - bits[5:4] state code.
    - Writing 1 to bit1 clears done; writing 1 to bit2 clears the error.
  - 3 FRAMES_DONE (read, [15:0]): frames completed in the current or last run.
  - 4 TOTAL (read, 32-bit): free-running count of fall events. Wraps at 2^32 − 1 → 0.
  - Addresses 5–7 read 0 and ignore writes.
- **State machine:** IDLE=0, ARM=1, RUN=2, STOP=3.
  - **IDLE:**
    - START or SNAP → ARM. This also clears FRAMES_DONE and the watchdog, and latches the mode (SNAP → snap mode).
    - If START and SNAP are set in the same write, SNAP wins.
  - **ARM:** waits for a frame boundary.
    - fs=0 → RUN, with ostart pulsed on the transition cycle.
    - STOP → IDLE with no pulses, and done is set.
  - **RUN:**
    - Each fall increments FRAMES_DONE, saturating at 0xFFFF.
    - In snap mode, the fall that makes FRAMES_DONE equal to max(NFRAMES,1) causes: oend pulse, done set, → IDLE.
    - STOP → STOP state.
  - **STOP:**
    - The next fall increments FRAMES_DONE, pulses oend, sets done and goes → IDLE.
    - If fs is already 0 on entry, this happens immediately: oend is pulsed on the entry-following cycle and FRAMES_DONE does not increment.
- **Watchdog:**
  - Counts up in ARM, RUN and STOP; clears on any rise or fall and on entry to ARM.
  - Reaching TIMEOUT_CYCLES causes: error set, done set, oend pulse (except from ARM), → IDLE.
- **Priorities and ignored commands:**
  - STOP beats SNAP and START in the same write.
  - START or SNAP while busy is ignored.
  - A timeout takes priority over a same-cycle fall or STOP.
  - A NFRAMES write during RUN takes effect on the next comparison.

## Timing
- **Reset values:** all outputs 0, state IDLE, NFRAMES=1, all counters 0, flags 0.
- **Reset mid-operation:** forces IDLE next cycle with no oend pulse. The capture stage is reset from the same reset tree.
- **Synchronizer latency:** a pin-level FVAL change is seen as fall/rise 3 iclk cycles later.
- **ostart:** asserts exactly 1 cycle, on the cycle after the ARM transition condition is seen.
- **Write latency:** a command write (iwrite high at edge k) changes state at edge k+1. obusy rises at k+1.
- **Read latency:** oreaddata is registered, valid at edge k+1 for iread at edge k, and holds until the next read.
- **Pulse spacing:** ostart and oend are never high in the same cycle. There is at least 1 cycle between consecutive ostart pulses.

## Test plan
- SNAP with NFRAMES=3 and FVAL running (frames of 1000 cycles, high 800): ostart once, oend after the 3rd fall + 3 cycles; FRAMES_DONE=3, done=1, busy=0, and oirq=1 when IRQ_EN is set.
- START, then STOP written mid-frame (fs=1): no oend until the next fall; then oend; FRAMES_DONE counts all completed frames.
- START issued while FVAL is high: ostart is delayed until fs=0. START issued again while busy: no second ostart.
- With TIMEOUT_CYCLES=100 and FVAL stuck high in RUN: after 100 cycles error=1, done=1, one oend pulse, state=IDLE. Writing 0x6 to STATUS clears both flags.
- CTRL=0x7 (START|STOP|SNAP) in IDLE: no state change and no pulses. NFRAMES=0 + SNAP: completes after 1 frame.
- Assert irst during RUN: next cycle obusy=0, ostart=oend=0, and all registers read back their reset values.

Source files
------------

// File: rtl/ccd_capture_sequencer_if.sv
// Avalon-MM register port between the Qsys host bridge and the capture sequencer.
interface ccd_capture_sequencer_if;
    logic [2:0]  iaddress;
    logic        iread;
    logic        iwrite;
    logic [31:0] iwritedata;
    logic [31:0] oreaddata;

    modport master (
        output iaddress,
        output iread,
        output iwrite,
        output iwritedata,
        input  oreaddata
    );

    modport slave (
        input  iaddress,
        input  iread,
        input  iwrite,
        input  iwritedata,
        output oreaddata
    );
endinterface

// File: rtl/ccd_capture_sequencer.sv
// Capture sequencer: turns host CTRL writes into frame-aligned start/end pulses for
// the CCD capture stage, counting frames off FVAL with a stall watchdog and interrupt.
module ccd_capture_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
    input  logic                   iclk,
    input  logic                   irst,
    ccd_capture_sequencer_if.slave avs,
    input  logic                   ifval,
    output logic                   ostart,
    output logic                   oend,
    output logic                   obusy,
    output logic                   oirq
);
    localparam int              WD_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] ADDR_CTRL    = 3'd0;
    localparam logic [2:0] ADDR_NFRAMES = 3'd1;
    localparam logic [2:0] ADDR_STATUS  = 3'd2;
    localparam logic [2:0] ADDR_FRAMES  = 3'd3;
    localparam logic [2:0] ADDR_TOTAL   = 3'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2,
        STOP = 2'd3
    } state_t;

    state_t          state_reg, state_next;
    logic [2:0]      fval_pipe_reg;
    logic            fs, fall, fval_edge;
    logic [15:0]     frames_reg, frames_next, frames_inc;
    logic [15:0]     nframes_reg, nframes_eff;
    logic [WD_W-1:0] wd_reg, wd_next;
    logic            done_reg, done_next;
    logic            error_reg, error_next;
    logic            snap_reg, snap_next;
    logic            start_pulse_reg, start_pulse_next;
    logic            end_pulse_reg, end_pulse_next;
    logic            irq_en_reg;
    logic [31:0]     total_reg;
    logic [31:0]     readdata_reg, read_value;
    logic            ctrl_wr, status_wr, cmd_start, cmd_stop, cmd_snap;
    logic            timeout, snap_hit;
    logic            unused_wdata;

    // Bits [1:0] are the two synchronizer stages, bit 2 is the edge-detect delay.
    assign fs        = fval_pipe_reg[1];
    assign fall      = fval_pipe_reg[2] & ~fval_pipe_reg[1];
    assign fval_edge = fval_pipe_reg[2] ^ fval_pipe_reg[1];

    assign ctrl_wr   = avs.iwrite && (avs.iaddress == ADDR_CTRL);
    assign status_wr = avs.iwrite && (avs.iaddress == ADDR_STATUS);
    assign cmd_start = avs.iwritedata[0];
    assign cmd_stop  = avs.iwritedata[1];
    assign cmd_snap  = avs.iwritedata[2];

    assign frames_inc  = (frames_reg == 16'hFFFF) ? frames_reg : frames_reg + 16'd1;
    assign nframes_eff = (nframes_reg == 16'd0) ? 16'd1 : nframes_reg;
    assign timeout     = (state_reg != IDLE) && (wd_reg == WD_LAST);
    assign snap_hit    = snap_reg && fall && (frames_inc == nframes_eff);

    assign ostart          = start_pulse_reg;
    assign oend            = end_pulse_reg;
    assign obusy           = (state_reg != IDLE);
    assign oirq            = done_reg & irq_en_reg;
    assign avs.oreaddata   = readdata_reg;
    assign unused_wdata    = ^avs.iwritedata[31:16];

    always_comb begin
        state_next       = state_reg;
        frames_next      = frames_reg;
        wd_next          = wd_reg;
        done_next        = done_reg;
        error_next       = error_reg;
        snap_next        = snap_reg;
        start_pulse_next = 1'b0;
        end_pulse_next   = 1'b0;

        if (status_wr && avs.iwritedata[1]) done_next  = 1'b0;
        if (status_wr && avs.iwritedata[2]) error_next = 1'b0;

        if (state_reg != IDLE)
            wd_next = fval_edge ? '0 : wd_reg + WD_W'(1);

        case (state_reg)
            IDLE: begin
                if (ctrl_wr && !cmd_stop && (cmd_start || cmd_snap)) begin
                    state_next  = ARM;
                    frames_next = '0;
                    wd_next     = '0;
                    snap_next   = cmd_snap;
                end
            end
            ARM: begin
                if (timeout) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                    error_next = 1'b1;
                end else if (ctrl_wr && cmd_stop) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end else if (!fs) begin
                    state_next       = RUN;
                    start_pulse_next = 1'b1;
                end
            end
            RUN: begin
                if (timeout) begin
                    state_next     = IDLE;
                    done_next      = 1'b1;
                    error_next     = 1'b1;
                    end_pulse_next = 1'b1;
                end else begin
                    if (fall) frames_next = frames_inc;
                    // A completing snapshot frame wins over a same-cycle STOP.
                    if (snap_hit) begin
                        state_next     = IDLE;
                        done_next      = 1'b1;
                        end_pulse_next = 1'b1;
                    end else if (ctrl_wr && cmd_stop) begin
                        state_next = STOP;
                    end
                end
            end
            STOP: begin
                if (timeout) begin
                    state_next     = IDLE;
                    done_next      = 1'b1;
                    error_next     = 1'b1;
                    end_pulse_next = 1'b1;
                end else if (!fs) begin
                    if (fall) frames_next = frames_inc;
                    state_next     = IDLE;
                    done_next      = 1'b1;
                    end_pulse_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge iclk) begin
        if (irst) begin
            state_reg       <= IDLE;
            frames_reg      <= '0;
            wd_reg          <= '0;
            done_reg        <= 1'b0;
            error_reg       <= 1'b0;
            snap_reg        <= 1'b0;
            start_pulse_reg <= 1'b0;
            end_pulse_reg   <= 1'b0;
        end else begin
            state_reg       <= state_next;
            frames_reg      <= frames_next;
            wd_reg          <= wd_next;
            done_reg        <= done_next;
            error_reg       <= error_next;
            snap_reg        <= snap_next;
            start_pulse_reg <= start_pulse_next;
            end_pulse_reg   <= end_pulse_next;
        end
    end

    always_comb begin
        read_value = '0;
        case (avs.iaddress)
            ADDR_NFRAMES: read_value = {16'd0, nframes_reg};
            ADDR_STATUS:  read_value = {26'd0, state_reg, snap_reg, error_reg, done_reg, obusy};
            ADDR_FRAMES:  read_value = {16'd0, frames_reg};
            ADDR_TOTAL:   read_value = total_reg;
            default:      read_value = '0;
        endcase
    end

    always_ff @(posedge iclk) begin
        if (irst) begin
            fval_pipe_reg <= '0;
            nframes_reg   <= 16'd1;
            irq_en_reg    <= 1'b0;
            total_reg     <= '0;
            readdata_reg  <= '0;
        end else begin
            fval_pipe_reg <= {fval_pipe_reg[1:0], ifval};
            if (avs.iwrite && (avs.iaddress == ADDR_NFRAMES))
                nframes_reg <= avs.iwritedata[15:0];
            if (ctrl_wr)
                irq_en_reg <= avs.iwritedata[3];
            if (fall)
                total_reg <= total_reg + 32'd1;
            if (avs.iread)
                readdata_reg <= read_value;
        end
    end
endmodule

// File: tb/tb_ccd_capture_sequencer.sv
// Self-checking bench for ccd_capture_sequencer: randomized frame timing, expected
// pulse cycles and register values derived from the FVAL waveform the bench drives.
`timescale 1ns/1ps
module tb_ccd_capture_sequencer;
    localparam int T = 100;
    localparam logic [2:0] A_CTRL = 3'd0;
    localparam logic [2:0] A_NFR  = 3'd1;
    localparam logic [2:0] A_STAT = 3'd2;
    localparam logic [2:0] A_FD   = 3'd3;
    localparam logic [2:0] A_TOT  = 3'd4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic fval = 1'b0;
    logic ostart, oend, obusy, oirq;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    int   both_cnt = 0;
    int   tot_model = 0;
    int   start_q[$];
    int   end_q[$];

    ccd_capture_sequencer_if avs_if();

    ccd_capture_sequencer #(.TIMEOUT_CYCLES(T)) dut (
        .iclk   (clk),
        .irst   (rst),
        .avs    (avs_if),
        .ifval  (fval),
        .ostart (ostart),
        .oend   (oend),
        .obusy  (obusy),
        .oirq   (oirq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse log: cycle index at which each ostart/oend pulse is visible.
    always @(negedge clk) begin
        if (ostart) start_q.push_back(cyc);
        if (oend) end_q.push_back(cyc);
        if (ostart && oend) both_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d, output int wc);
        avs_if.iaddress   = a;
        avs_if.iwritedata = d;
        avs_if.iwrite     = 1'b1;
        wc = cyc;
        tick(1);
        avs_if.iwrite = 1'b0;
        $display("write addr=%0d data=0x%08h cycle=%0d", a, d, wc);
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        avs_if.iaddress = a;
        avs_if.iread    = 1'b1;
        tick(1);
        avs_if.iread = 1'b0;
        d = avs_if.oreaddata;
        $display("read  addr=%0d data=0x%08h cycle=%0d", a, d, cyc);
    endtask

    task automatic fval_set(input logic v);
        if (fval && !v) tot_model++;
        fval = v;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        int tmp;
        vectors++;
        if ({ostart, oend, obusy, oirq} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b expected 0000", {ostart, oend, obusy, oirq});
        end
        for (int a = 0; a < 8; a++) begin
            bus_read(3'(a), rd);
            vectors++;
            if (rd !== ((a == 1) ? 32'd1 : 32'd0)) begin
                miscompares++;
                $display("FAIL reset_reg%0d: got 0x%08h expected 0x%08h", a, rd, (a == 1) ? 1 : 0);
            end
        end
        bus_read(A_NFR, rd);
        tick(3);
        vectors++;
        if (avs_if.oreaddata !== 32'd1) begin
            miscompares++;
            $display("FAIL readdata_hold: got 0x%08h expected 0x00000001", avs_if.oreaddata);
        end
        bus_write(3'd5, $urandom, tmp);
        bus_read(3'd5, rd);
        vectors++;
        if (rd !== 32'd0) begin
            miscompares++;
            $display("FAIL unmapped_addr: got 0x%08h expected 0", rd);
        end
    endtask

    task automatic test_ctrl_all_bits();
        logic [31:0] rd;
        int w;
        start_q.delete(); end_q.delete();
        bus_write(A_CTRL, 32'h7, w);
        tick(4);
        vectors++;
        if (obusy !== 1'b0 || start_q.size() != 0 || end_q.size() != 0) begin
            miscompares++;
            $display("FAIL ctrl7_ignored: got busy=%b starts=%0d ends=%0d expected 0/0/0", obusy, start_q.size(), end_q.size());
        end
        bus_read(A_STAT, rd);
        vectors++;
        if (rd !== 32'h0) begin
            miscompares++;
            $display("FAIL ctrl7_status: got 0x%08h expected 0", rd);
        end
    endtask

    task automatic test_snap();
        for (int it = 0; it < 3; it++) begin
            logic [31:0] rd;
            int n, irq, w, tmp, lastf, got;
            n   = $urandom_range(1, 5);
            irq = $urandom_range(0, 1);
            start_q.delete(); end_q.delete();
            bus_write(A_NFR, 32'(n), tmp);
            bus_write(A_CTRL, 32'h4 | 32'(irq << 3), w);
            tick(3);
            for (int f = 0; f < n; f++) begin
                fval_set(1'b1); tick($urandom_range(20, 60));
                fval_set(1'b0); lastf = cyc; tick($urandom_range(10, 30));
            end
            fval_set(1'b1); tick(20); fval_set(1'b0); tick(10);
            got = (start_q.size() == 1) ? start_q[0] : -1;
            vectors++;
            if (got !== w + 2) begin
                miscompares++;
                $display("FAIL snap_ostart: got cycle %0d (count %0d) expected %0d", got, start_q.size(), w + 2);
            end
            got = (end_q.size() == 1) ? end_q[0] : -1;
            vectors++;
            if (got !== lastf + 3) begin
                miscompares++;
                $display("FAIL snap_oend: got cycle %0d (count %0d) expected %0d", got, end_q.size(), lastf + 3);
            end
            bus_read(A_FD, rd);
            vectors++;
            if (rd !== 32'(n)) begin
                miscompares++;
                $display("FAIL snap_frames: got %0d expected %0d", rd, n);
            end
            bus_read(A_STAT, rd);
            vectors++;
            if (rd !== 32'h0A) begin
                miscompares++;
                $display("FAIL snap_status: got 0x%08h expected 0x0000000a", rd);
            end
            vectors++;
            if (oirq !== 1'(irq)) begin
                miscompares++;
                $display("FAIL snap_irq: got %b expected %0d", oirq, irq);
            end
            bus_read(A_TOT, rd);
            vectors++;
            if (rd !== 32'(tot_model)) begin
                miscompares++;
                $display("FAIL snap_total: got %0d expected %0d", rd, tot_model);
            end
            bus_write(A_STAT, 32'h2, tmp);
            tick(1);
            vectors++;
            if (oirq !== 1'b0) begin
                miscompares++;
                $display("FAIL snap_irq_clear: got %b expected 0", oirq);
            end
        end
    endtask

    task automatic test_nframes_zero();
        logic [31:0] rd;
        int w, tmp, f, got;
        start_q.delete(); end_q.delete();
        bus_write(A_NFR, 32'h0, tmp);
        bus_read(A_NFR, rd);
        vectors++;
        if (rd !== 32'h0) begin
            miscompares++;
            $display("FAIL nframes0_readback: got %0d expected 0", rd);
        end
        bus_write(A_CTRL, 32'h4, w);
        tick(3);
        fval_set(1'b1); tick($urandom_range(20, 60));
        fval_set(1'b0); f = cyc; tick(10);
        got = (end_q.size() == 1) ? end_q[0] : -1;
        vectors++;
        if (got !== f + 3) begin
            miscompares++;
            $display("FAIL nframes0_oend: got cycle %0d (count %0d) expected %0d", got, end_q.size(), f + 3);
        end
        bus_read(A_FD, rd);
        vectors++;
        if (rd !== 32'd1) begin
            miscompares++;
            $display("FAIL nframes0_frames: got %0d expected 1", rd);
        end
        bus_write(A_STAT, 32'h2, tmp);
    endtask

    task automatic test_start_stop();
        logic [31:0] rd;
        int k, w, s, f, tmp, got;
        k = $urandom_range(1, 3);
        start_q.delete(); end_q.delete();
        bus_write(A_CTRL, 32'h1, w);
        tick(3);
        for (int i = 0; i < k; i++) begin
            fval_set(1'b1); tick($urandom_range(20, 60));
            fval_set(1'b0); tick($urandom_range(10, 30));
        end
        fval_set(1'b1); tick($urandom_range(5, 20));
        bus_write(A_CTRL, 32'h2, s);
        tick($urandom_range(5, 30));
        vectors++;
        if (end_q.size() != 0) begin
            miscompares++;
            $display("FAIL stop_early_oend: got %0d pulses expected 0", end_q.size());
        end
        bus_read(A_STAT, rd);
        vectors++;
        if (rd !== 32'h31) begin
            miscompares++;
            $display("FAIL stop_state: got 0x%08h expected 0x00000031", rd);
        end
        fval_set(1'b0); f = cyc; tick(10);
        got = (end_q.size() == 1) ? end_q[0] : -1;
        vectors++;
        if (got !== f + 3) begin
            miscompares++;
            $display("FAIL stop_oend: got cycle %0d (count %0d) expected %0d", got, end_q.size(), f + 3);
        end
        got = (start_q.size() == 1) ? start_q[0] : -1;
        vectors++;
        if (got !== w + 2) begin
            miscompares++;
            $display("FAIL stop_ostart: got cycle %0d (count %0d) expected %0d", got, start_q.size(), w + 2);
        end
        bus_read(A_FD, rd);
        vectors++;
        if (rd !== 32'(k + 1)) begin
            miscompares++;
            $display("FAIL stop_frames: got %0d expected %0d", rd, k + 1);
        end
        bus_read(A_STAT, rd);
        vectors++;
        if (rd !== 32'h02) begin
            miscompares++;
            $display("FAIL stop_status: got 0x%08h expected 0x00000002", rd);
        end
        bus_write(A_STAT, 32'h2, tmp);
    endtask

    task automatic test_start_fval_high();
        logic [31:0] rd;
        int w, s, f0, tmp, got;
        start_q.delete(); end_q.delete();
        fval_set(1'b1); tick(6);
        bus_write(A_CTRL, 32'h1, w);
        tick($urandom_range(3, 30));
        bus_write(A_CTRL, 32'h1, tmp);
        fval_set(1'b0); f0 = cyc; tick(8);
        got = (start_q.size() == 1) ? start_q[0] : -1;
        vectors++;
        if (got !== f0 + 3) begin
            miscompares++;
            $display("FAIL armed_ostart: got cycle %0d (count %0d) expected %0d", got, start_q.size(), f0 + 3);
        end
        fval_set(1'b1); tick($urandom_range(10, 40));
        bus_write(A_CTRL, 32'h5, tmp);
        fval_set(1'b0); tick(6);
        bus_write(A_CTRL, 32'h2, s);
        tick(5);
        vectors++;
        if (start_q.size() != 1) begin
            miscompares++;
            $display("FAIL busy_restart: got %0d ostart pulses expected 1", start_q.size());
        end
        got = (end_q.size() == 1) ? end_q[0] : -1;
        vectors++;
        if (got !== s + 2) begin
            miscompares++;
            $display("FAIL stop_low_oend: got cycle %0d (count %0d) expected %0d", got, end_q.size(), s + 2);
        end
        bus_read(A_FD, rd);
        vectors++;
        if (rd !== 32'd1) begin
            miscompares++;
            $display("FAIL stop_low_frames: got %0d expected 1", rd);
        end
        bus_read(A_STAT, rd);
        vectors++;
        if (rd !== 32'h02) begin
            miscompares++;
            $display("FAIL stop_low_status: got 0x%08h expected 0x00000002", rd);
        end
        bus_write(A_STAT, 32'h2, tmp);
    endtask

    task automatic test_timeout_run();
        logic [31:0] rd;
        int w, r, tmp, got;
        start_q.delete(); end_q.delete();
        bus_write(A_CTRL, 32'h1, w);
        tick($urandom_range(3, 10));
        fval_set(1'b1); r = cyc;
        tick(r + T + 2 - cyc);
        vectors++;
        if (obusy !== 1'b1 || oend !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_run_early: got busy=%b oend=%b expected 1/0", obusy, oend);
        end
        tick(1);
        vectors++;
        if (obusy !== 1'b0 || oend !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_run_fire: got busy=%b oend=%b expected 0/1", obusy, oend);
        end
        tick(5);
        got = (end_q.size() == 1) ? end_q[0] : -1;
        vectors++;
        if (got !== r + T + 3) begin
            miscompares++;
            $display("FAIL timeout_run_oend: got cycle %0d (count %0d) expected %0d", got, end_q.size(), r + T + 3);
        end
        bus_read(A_STAT, rd);
        vectors++;
        if (rd !== 32'h06) begin
            miscompares++;
            $display("FAIL timeout_run_status: got 0x%08h expected 0x00000006", rd);
        end
        bus_write(A_STAT, 32'h6, tmp);
        bus_read(A_STAT, rd);
        vectors++;
        if (rd !== 32'h00) begin
            miscompares++;
            $display("FAIL timeout_clear: got 0x%08h expected 0", rd);
        end
        fval_set(1'b0); tick(5);
    endtask

    task automatic test_timeout_arm();
        logic [31:0] rd;
        int w, tmp;
        start_q.delete(); end_q.delete();
        fval_set(1'b1); tick(6);
        bus_write(A_CTRL, 32'h9, w);
        tick(w + T - cyc);
        vectors++;
        if (obusy !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_arm_early: got busy=%b expected 1", obusy);
        end
        tick(1);
        vectors++;
        if (obusy !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_arm_fire: got busy=%b expected 0", obusy);
        end
        tick(3);
        vectors++;
        if (start_q.size() != 0 || end_q.size() != 0) begin
            miscompares++;
            $display("FAIL timeout_arm_pulses: got starts=%0d ends=%0d expected 0/0", start_q.size(), end_q.size());
        end
        bus_read(A_STAT, rd);
        vectors++;
        if (rd !== 32'h06 || oirq !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_arm_status: got 0x%08h irq=%b expected 0x00000006 irq=1", rd, oirq);
        end
        bus_write(A_STAT, 32'h6, tmp);
        tick(1);
        vectors++;
        if (oirq !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_arm_irq_clear: got %b expected 0", oirq);
        end
        bus_write(A_CTRL, 32'h0, tmp);
        fval_set(1'b0); tick(5);
    endtask

    task automatic test_reset_mid_run();
        logic [31:0] rd;
        int w;
        start_q.delete(); end_q.delete();
        bus_write(A_NFR, 32'h7, w);
        bus_write(A_CTRL, 32'h1, w);
        tick(3);
        fval_set(1'b1); tick(30); fval_set(1'b0); tick(15);
        fval_set(1'b1); tick($urandom_range(5, 30));
        rst = 1'b1;
        tick(1);
        vectors++;
        if ({obusy, ostart, oend} !== 3'b000) begin
            miscompares++;
            $display("FAIL midrun_reset_outputs: got %b expected 000", {obusy, ostart, oend});
        end
        rst = 1'b0;
        tot_model = 0;
        for (int a = 0; a < 5; a++) begin
            bus_read(3'(a), rd);
            vectors++;
            if (rd !== ((a == 1) ? 32'd1 : 32'd0)) begin
                miscompares++;
                $display("FAIL midrun_reset_reg%0d: got 0x%08h expected 0x%08h", a, rd, (a == 1) ? 1 : 0);
            end
        end
        vectors++;
        if (end_q.size() != 0) begin
            miscompares++;
            $display("FAIL midrun_reset_oend: got %0d pulses expected 0", end_q.size());
        end
        fval_set(1'b0); tick(6);
        bus_read(A_TOT, rd);
        vectors++;
        if (rd !== 32'(tot_model)) begin
            miscompares++;
            $display("FAIL midrun_total: got %0d expected %0d", rd, tot_model);
        end
    endtask

    initial begin
        avs_if.iaddress   = '0;
        avs_if.iread      = 1'b0;
        avs_if.iwrite     = 1'b0;
        avs_if.iwritedata = '0;
        rst = 1'b1;
        tick(4);
        rst = 1'b0;
        tick(2);
        test_reset();
        test_ctrl_all_bits();
        test_snap();
        test_nframes_zero();
        test_start_stop();
        test_start_fval_high();
        test_timeout_run();
        test_timeout_arm();
        test_reset_mid_run();
        vectors++;
        if (both_cnt !== 0) begin
            miscompares++;
            $display("FAIL pulse_overlap: got %0d overlapping cycles expected 0", both_cnt);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
